read_pattern_source: RTL and testbench

READ_PATTERN_SOURCE -- requirements
Module: read_pattern_source

---
 rtl/read_pattern_source.sv | 125 ++++++++++++
 tb/tb_read_pattern_source.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/read_pattern_source.sv
// read_pattern_source: pattern generator feeding a 64-bit FIFO drained as 32-bit words by a pipe-out host.
// Defining READ_PATTERN_INJECT_ERR_EN adds inject_error, which flips bit 0 of the next successfully read word.
module read_pattern_source #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        okClk,
  input  logic        reset,
  input  logic        reset_pattern,
  input  logic [31:0] pattern,
  input  logic        start_timer,
  input  logic        stop_timer,
  input  logic        pipe_out_read,
`ifdef READ_PATTERN_INJECT_ERR_EN
  input  logic        inject_error,
`endif
  output logic [31:0] pipe_out_data,
  output logic [63:0] clk_counts,
  output logic [31:0] words_sent,
  output logic [31:0] underrun_count,
  output logic        timer_on,
  output logic        buf_empty,
  output logic        buf_full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] UNDERRUN_WORD = 32'hDEAD_BEEF;

  function automatic logic [31:0] nxt(input logic [1:0] m, input logic [31:0] w);
    return m == 2'd0 ? w + 32'd1 :
           m == 2'd1 ? {w[30:0], w[31]} :
           m == 2'd2 ? (w >> 1) ^ (w[0] ? 32'h8020_0003 : 32'h0) : ~w;
  endfunction

  function automatic logic [31:0] seed(input logic [1:0] m);
    return m == 2'd0 ? 32'h0 : m == 2'd3 ? 32'hAAAA_AAAA : 32'h1;
  endfunction

  logic [1:0]            mode_q;
  logic [31:0]           gen_q, gen_w1, gen_w2;
  logic [63:0]           mem_q [DEPTH];
  logic [63:0]           entry;
  logic [DEPTH_LOG2-1:0] wr_q, rd_q;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  empty_q, full_q, half_q;
  logic                  flush, rd_ok, rd_under, pop, wr, flip;
  logic [31:0]           data_q, data_d, words_q, under_q;
  logic [63:0]           clk_q;
  logic                  ton_q, ton_d, clk_inc;
  logic                  unused_pattern;

  assign unused_pattern = ^pattern[31:2];

  always_comb begin
    flush    = reset | reset_pattern;
    rd_ok    = pipe_out_read & ~empty_q & ~flush;
    rd_under = pipe_out_read & empty_q & ~flush;
    pop      = rd_ok & half_q;
    wr       = (~full_q | pop) & ~flush;
    gen_w1   = nxt(mode_q, gen_q);
    gen_w2   = nxt(mode_q, gen_w1);
    entry    = mem_q[rd_q];
    cnt_d    = cnt_q + {{DEPTH_LOG2{1'b0}}, wr} - {{DEPTH_LOG2{1'b0}}, pop};
    ton_d    = ~stop_timer & (start_timer | ton_q);
    clk_inc  = start_timer | (ton_q & ~stop_timer);
    data_d   = rd_under ? UNDERRUN_WORD : (half_q ? entry[31:0] : entry[63:32]) ^ {31'b0, flip};
  end

  // When full, a pop frees the slot being overwritten; the read uses the old contents.
  always_ff @(posedge okClk)
    if (wr) mem_q[wr_q] <= {gen_q, gen_w1};

  always_ff @(posedge okClk) begin
    if (flush) begin
      mode_q  <= pattern[1:0];
      gen_q   <= seed(pattern[1:0]);
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      half_q  <= 1'b0;
    end else begin
      if (wr) wr_q <= wr_q + 1'b1;
      if (wr) gen_q <= gen_w2;
      if (pop) rd_q <= rd_q + 1'b1;
      if (rd_ok) half_q <= ~half_q;
      cnt_q   <= cnt_d;
      empty_q <= cnt_d == '0;
      full_q  <= cnt_d == DEPTH[DEPTH_LOG2:0];
    end
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      data_q  <= '0;
      words_q <= '0;
      under_q <= '0;
      clk_q   <= '0;
      ton_q   <= 1'b0;
    end else begin
      ton_q <= ton_d;
      if (clk_inc) clk_q <= clk_q + 64'd1;
      if (rd_ok | rd_under) data_q <= data_d;
      if (rd_ok) words_q <= words_q + 32'd1;
      if (rd_under) under_q <= under_q + 32'd1;
    end
  end

`ifdef READ_PATTERN_INJECT_ERR_EN
  logic inj_q;
  always_ff @(posedge okClk)
    if (reset) inj_q <= 1'b0;
    else inj_q <= rd_ok ? 1'b0 : inj_q | inject_error;
  assign flip = inj_q | inject_error;
`else
  assign flip = 1'b0;
`endif

  assign pipe_out_data  = data_q;
  assign clk_counts     = clk_q;
  assign words_sent     = words_q;
  assign underrun_count = under_q;
  assign timer_on       = ton_q;
  assign buf_empty      = empty_q;
  assign buf_full       = full_q;
endmodule

// File: tb/tb_read_pattern_source.sv
// tb_read_pattern_source: randomized scoreboard bench; the reference model derives words from the pattern rules by index.
module tb_read_pattern_source;
  localparam int DL = 3;
  localparam int DEPTH = 1 << DL;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic okClk = 0, reset = 0, reset_pattern = 0, start_timer = 0, stop_timer = 0;
  logic pipe_out_read = 0, inject_error = 0;
  logic [31:0] pattern = 0;
  logic [31:0] pipe_out_data, words_sent, underrun_count;
  logic [63:0] clk_counts;
  logic timer_on, buf_empty, buf_full;

  always #5 okClk = ~okClk;

  read_pattern_source #(.DEPTH_LOG2(DL)) dut (
    .okClk(okClk), .reset(reset), .reset_pattern(reset_pattern), .pattern(pattern),
    .start_timer(start_timer), .stop_timer(stop_timer), .pipe_out_read(pipe_out_read),
`ifdef READ_PATTERN_INJECT_ERR_EN
    .inject_error(inject_error),
`endif
    .pipe_out_data(pipe_out_data), .clk_counts(clk_counts), .words_sent(words_sent),
    .underrun_count(underrun_count), .timer_on(timer_on), .buf_empty(buf_empty), .buf_full(buf_full)
  );

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  m_mode;
  int          m_wr, m_rd;
  logic [31:0] m_words, m_under, m_data;
  logic [63:0] m_clk;
  bit          m_ton, m_inj, m_valid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Word n of a stream, straight from the pattern definitions.
  function automatic logic [31:0] word_of(input logic [1:0] m, input int n);
    logic [31:0] w;
    if (m == 2'd0) return 32'(n);
    if (m == 2'd1) return 32'h1 << (n % 32);
    if (m == 2'd3) return (n % 2) ? 32'h5555_5555 : 32'hAAAA_AAAA;
    w = 32'h1;
    for (int i = 0; i < n; i++) w = w[0] ? (w >> 1) ^ 32'h8020_0003 : w >> 1;
    return w;
  endfunction

  task automatic tick();
    int occ;
    bit pop, fl;
    occ = m_wr - m_rd / 2;
    if (m_valid) begin
      chk("buf_empty", buf_empty, occ == 0);
      chk("buf_full", buf_full, occ == DEPTH);
      chk("timer_on", timer_on, m_ton);
      chk("clk_counts", clk_counts, m_clk);
      chk("words_sent", words_sent, m_words);
      chk("underrun_count", underrun_count, m_under);
      chk("data_hold", pipe_out_data, m_data);
    end
    if (reset) begin
      m_mode = pattern[1:0]; m_wr = 0; m_rd = 0; m_words = 0; m_under = 0;
      m_data = 0; m_clk = 0; m_ton = 0; m_inj = 0; m_valid = 1;
    end else begin
      if (start_timer || m_ton && !stop_timer) m_clk++;
      if (start_timer && stop_timer) m_ton = 0;
      else if (start_timer) m_ton = 1;
      else if (stop_timer) m_ton = 0;
`ifdef READ_PATTERN_INJECT_ERR_EN
      fl = m_inj | inject_error;
`else
      fl = 0;
`endif
      if (reset_pattern) begin
        m_mode = pattern[1:0]; m_wr = 0; m_rd = 0; m_inj = fl;
      end else begin
        pop = 0;
        if (pipe_out_read && occ > 0) begin
          m_data = word_of(m_mode, m_rd) ^ {31'b0, fl};
          pop = m_rd % 2 == 1;
          m_rd++; m_words++; m_inj = 0;
          exp_q.push_back(m_data);
        end else begin
          m_inj = fl;
          if (pipe_out_read) begin
            m_data = DEAD; m_under++;
            exp_q.push_back(DEAD);
          end
        end
        if (occ < DEPTH || pop) m_wr++;
      end
    end
    @(posedge okClk); #1;
    reset = 0; reset_pattern = 0; start_timer = 0; stop_timer = 0; pipe_out_read = 0; inject_error = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input int n);
    repeat (n) begin pipe_out_read = 1; tick(); end
  endtask

  task automatic do_reset(input logic [1:0] m);
    pattern = {$urandom, m}; reset = 1; tick();
  endtask

  bit rd_seen = 0;
  always @(posedge okClk) rd_seen <= pipe_out_read & ~reset & ~reset_pattern;
  always @(negedge okClk)
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard: got %h expected nothing (queue empty)", pipe_out_data);
      end else chk("pipe_out_data", pipe_out_data, exp_q.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge okClk); #1;
    do_reset(0);
    rd(1);
    rd(1);
    do_reset(0); idle(4); rd(8);
    chk("words_sent_8", words_sent, 8);
    chk("underrun_0", underrun_count, 0);
    do_reset(2); idle(4); rd(3);
    do_reset(1); idle(4); rd(5);
    pattern = 32'hFFFF_FFFC; reset_pattern = 1; tick();
    pattern = 32'h3; idle(2); rd(3);
    chk("words_sent_after_reseed", words_sent, 8);
    start_timer = 1; tick(); idle(99);
    stop_timer = 1; tick();
    chk("clk_100", clk_counts, 100);
    start_timer = 1; stop_timer = 1; tick();
    chk("clk_101", clk_counts, 101);
    chk("timer_off", timer_on, 0);
    do_reset(3); idle(DEPTH + 3); rd(2 * DEPTH + 6);
    for (int ph = 0; ph < 4; ph++) begin
      do_reset(2'($urandom));
      for (int i = 0; i < 150; i++) begin
        pipe_out_read = $urandom_range(0, 3) <= ph;
        pattern = $urandom;
        start_timer = $urandom_range(0, 30) == 0;
        stop_timer = $urandom_range(0, 30) == 0;
        inject_error = $urandom_range(0, 20) == 0;
        if ($urandom_range(0, 40) == 0) begin reset_pattern = 1; pipe_out_read = 0; end
        tick();
      end
    end
`ifdef READ_PATTERN_INJECT_ERR_EN
    do_reset(3); idle(3); rd(1);
    inject_error = 1; tick();
    rd(2);
    chk("inject_last", pipe_out_data, 32'hAAAA_AAAA);
`endif
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
